mux_b: RTL and testbench
========================

# mux_b

Operand-B source selector for the accumulator datapath: picks either the data-memory read word or the instruction immediate and presents it to the ALU's B input. It sits between the data memory/instruction decoder and the ALU and is steered by the control unit's SelB line. The output is combinational by default; an optional registered output stage is compiled in for pipelined builds.

## Interface
Clock and reset are Clk and Rst_n: one clock, asynchronous active-low reset.

**Parameters**
- DATA_W, 16, width of the memory word and of the ALU operand.
- IMM_W, 16, width of the Immediate input; must satisfy 1 <= IMM_W <= DATA_W.

**Ports**
- Clk  in  1  rising-edge clock; used only when MUXB_REG_OUT_EN is defined.
- Rst_n  in  1  asynchronous active-low reset; used only when MUXB_REG_OUT_EN is defined.
- Memory  in  DATA_W  data-memory read word.
- Immediate  in  IMM_W  instruction operand field.
- SignExt  in  1  1 = sign-extend Immediate to DATA_W, 0 = zero-extend. Ignored when IMM_W == DATA_W.
- SelB  in  1  0 selects Memory, 1 selects the extended Immediate.
- En  in  1  load enable for the output register; ignored in combinational mode.
- Alu  out  DATA_W  operand B to the ALU.
- AluZero  out  1  high when Alu == 0.
- AluSrc  out  1  source of the current Alu value (copy of the SelB that produced it).

## Operation
- ImmExt = {(DATA_W-IMM_W) copies of (SignExt & Immediate[IMM_W-1]), Immediate}. With IMM_W == DATA_W, ImmExt = Immediate.
- Sel = SelB ? ImmExt : Memory.
- SelB X/Z: treated as 0 (Memory). No X propagation from the select.
- AluZero = (Alu == 0).
- AluSrc = the SelB value that produced the current Alu.
- No arithmetic is performed. Values pass bit-exact. There is no overflow case.

## Timing
- **Combinational mode** (macro undefined):
  - Alu = Sel and AluSrc = SelB, with zero latency.
  - Clk, Rst_n and En have no effect.
  - Outputs follow inputs at all times.
- **Registered mode** (macro defined):
  - While Rst_n = 0: Alu = 0, AluSrc = 0, AluZero = 1, asynchronously.
  - First capture happens on the first rising Clk edge after Rst_n deasserts.
  - On a rising Clk edge with En = 1: Alu <= Sel and AluSrc <= SelB. Latency is 1 cycle.
  - En = 0: outputs hold their value.
  - SelB or input changes between edges are invisible at the outputs.
  - Reset asserted mid-operation clears the outputs immediately, regardless of Clk.
- AluZero is always derived combinationally from the Alu output, in both modes.

## Configuration
- MUXB_REG_OUT_EN defined: the output register is instantiated and the registered-mode timing applies.
- MUXB_REG_OUT_EN undefined: the block is purely combinational (the default build).

## Structure
- Shared package holds:
  - the DATA_W default (16);
  - SEL_MEMORY = 1'b0 and SEL_IMMEDIATE = 1'b1;
  - a typedef for the DATA_W-wide operand word.
- Natural sub-module: imm_extend, a parameterised IMM_W->DATA_W sign/zero extender.
- Everything else stays in mux_b.

## Test plan
- All inputs 0, SelB = 0 -> Alu = 0, AluZero = 1, AluSrc = 0.
- Memory = 247, Immediate = 0, SelB = 0 -> Alu = 247, AluZero = 0.
- Memory = 247, Immediate = 2222, SelB = 1 -> Alu = 2222, AluSrc = 1. Then SelB = 0 -> Alu = 247.
- IMM_W = 11, Immediate = 11'h7FF:
  - SignExt = 1, SelB = 1 -> Alu = 16'hFFFF.
  - SignExt = 0 -> Alu = 16'h07FF.
- Registered build, Rst_n = 0 -> Alu = 0 asynchronously.
  - Release reset, Memory = 247, SelB = 0, En = 1 -> Alu = 247 one edge later.
  - En = 0, SelB = 1 -> Alu stays 247.
- Registered build, assert Rst_n mid-clock while Alu = 2222 -> Alu = 0 before the next edge.

Source files
------------

// File: rtl/mux_b_pkg.sv
// rtl/mux_b_pkg.sv - shared constants and types for the ALU operand-B selector
package mux_b_pkg;

  localparam int DATA_W_DEFAULT = 16;

  localparam logic SEL_MEMORY    = 1'b0;
  localparam logic SEL_IMMEDIATE = 1'b1;

  typedef logic [DATA_W_DEFAULT-1:0] operand_t;

endpackage

// File: rtl/mux_b_imm_extend.sv
// rtl/mux_b_imm_extend.sv - IMM_W to DATA_W sign/zero extender for the immediate operand
module imm_extend #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 16
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext
);

  generate
    if (IMM_W == DATA_W) begin : g_pass
      // Full-width immediate: nothing to extend, so the sign control is irrelevant.
      logic unused_sign_ext;
      assign unused_sign_ext = sign_ext;
      assign ext = imm;
    end else begin : g_ext
      assign ext = {{(DATA_W-IMM_W){sign_ext & imm[IMM_W-1]}}, imm};
    end
  endgenerate

endmodule

// File: rtl/mux_b.sv
// rtl/mux_b.sv - ALU operand-B selector (memory word or extended immediate)
// Define MUXB_REG_OUT_EN for the registered output stage; default build is combinational.
module mux_b
  import mux_b_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IMM_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] Memory,
  input  logic [IMM_W-1:0]  Immediate,
  input  logic              SignExt,
  input  logic              SelB,
  input  logic              En,
  output logic [DATA_W-1:0] Alu,
  output logic              AluZero,
  output logic              AluSrc
);

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] sel;
  logic              sel_src;

  imm_extend #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W)
  ) u_imm_extend (
    .imm     (Immediate),
    .sign_ext(SignExt),
    .ext     (imm_ext)
  );

  // An unknown select falls to the else branch, so X/Z on SelB picks Memory.
  always_comb begin
    sel     = Memory;
    sel_src = SEL_MEMORY;
    if (SelB == SEL_IMMEDIATE) begin
      sel     = imm_ext;
      sel_src = SEL_IMMEDIATE;
    end
  end

`ifdef MUXB_REG_OUT_EN
  logic [DATA_W-1:0] alu_q;
  logic              src_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      alu_q <= '0;
      src_q <= SEL_MEMORY;
    end else if (En) begin
      alu_q <= sel;
      src_q <= sel_src;
    end
  end

  assign Alu    = alu_q;
  assign AluSrc = src_q;
`else
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, Clk, Rst_n, En};

  assign Alu    = sel;
  assign AluSrc = sel_src;
`endif

  assign AluZero = (Alu == '0);

endmodule

// File: tb/tb_mux_b.sv
// tb/tb_mux_b.sv - scoreboard bench for mux_b (combinational and MUXB_REG_OUT_EN builds)
module tb_mux_b;
  import mux_b_pkg::*;

  typedef struct packed {
    operand_t alu;
    logic     src;
    logic     zero;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        En;
  logic        SignExt;
  logic        SelB;
  operand_t    Memory;
  logic [15:0] Immediate;
  logic [10:0] imm11;
  operand_t    alu, alu11;
  logic        alu_zero, alu_src, zero11, src11;

  exp_t sb[$];
  exp_t e;
  exp_t hold16, hold11;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  mux_b #(.DATA_W(16), .IMM_W(16)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Memory(Memory), .Immediate(Immediate),
    .SignExt(SignExt), .SelB(SelB), .En(En),
    .Alu(alu), .AluZero(alu_zero), .AluSrc(alu_src)
  );

  mux_b #(.DATA_W(16), .IMM_W(11)) u_dut11 (
    .Clk(Clk), .Rst_n(Rst_n), .Memory(Memory), .Immediate(imm11),
    .SignExt(SignExt), .SelB(SelB), .En(En),
    .Alu(alu11), .AluZero(zero11), .AluSrc(src11)
  );

  function automatic operand_t model_ext(input logic [15:0] imm, input logic sext, input int w);
    operand_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = (i < w) ? imm[i] : (sext & imm[w-1]);
    return r;
  endfunction

  function automatic exp_t model(input operand_t mem, input logic [15:0] imm,
                                 input logic sext, input logic selb, input int w);
    exp_t r;
    r.alu  = (selb === 1'b1) ? model_ext(imm, sext, w) : mem;
    r.src  = (selb === 1'b1);
    r.zero = (r.alu == 16'd0);
    return r;
  endfunction

  task automatic drive(input operand_t mem, input logic [15:0] imm, input logic sext, input logic selb);
    Memory    = mem;
    Immediate = imm;
    imm11     = imm[10:0];
    SignExt   = sext;
    SelB      = selb;
  endtask

  // Registered build needs a capturing edge; combinational build only needs settling.
  task automatic settle();
`ifdef MUXB_REG_OUT_EN
    @(posedge Clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_zero();
    drive(16'd0, 16'd0, 1'b0, 1'b0);
    sb.push_back(model(16'd0, 16'd0, 1'b0, 1'b0, 16));
    settle();
    e = sb.pop_front();
    total++;
    if ({alu, alu_zero, alu_src} !== {e.alu, e.zero, e.src}) begin
      bad++;
      $display("FAIL zero: alu=%h zero=%b src=%b expected alu=%h zero=%b src=%b", alu, alu_zero, alu_src, e.alu, e.zero, e.src);
    end
  endtask

  task automatic test_memory();
    drive(16'd247, 16'd0, 1'b0, 1'b0);
    sb.push_back(model(16'd247, 16'd0, 1'b0, 1'b0, 16));
    settle();
    e = sb.pop_front();
    total++;
    if ({alu, alu_zero, alu_src} !== {e.alu, e.zero, e.src}) begin
      bad++;
      $display("FAIL memory: alu=%h zero=%b src=%b expected alu=%h zero=%b src=%b", alu, alu_zero, alu_src, e.alu, e.zero, e.src);
    end
  endtask

  task automatic test_immediate();
    drive(16'd247, 16'd2222, 1'b0, 1'b1);
    sb.push_back(model(16'd247, 16'd2222, 1'b0, 1'b1, 16));
    settle();
    e = sb.pop_front();
    total++;
    if ({alu, alu_zero, alu_src} !== {e.alu, e.zero, e.src}) begin
      bad++;
      $display("FAIL immediate: alu=%h zero=%b src=%b expected alu=%h zero=%b src=%b", alu, alu_zero, alu_src, e.alu, e.zero, e.src);
    end
    drive(16'd247, 16'd2222, 1'b0, 1'b0);
    sb.push_back(model(16'd247, 16'd2222, 1'b0, 1'b0, 16));
    settle();
    e = sb.pop_front();
    total++;
    if ({alu, alu_zero, alu_src} !== {e.alu, e.zero, e.src}) begin
      bad++;
      $display("FAIL imm_back_to_mem: alu=%h zero=%b src=%b expected alu=%h zero=%b src=%b", alu, alu_zero, alu_src, e.alu, e.zero, e.src);
    end
  endtask

  task automatic test_sign_ext();
    for (int s = 1; s >= 0; s--) begin
      drive(16'd247, 16'h07FF, s[0], 1'b1);
      sb.push_back(model(16'd247, 16'h07FF, s[0], 1'b1, 11));
      settle();
      e = sb.pop_front();
      total++;
      if ({alu11, zero11, src11} !== {e.alu, e.zero, e.src}) begin
        bad++;
        $display("FAIL sign_ext%0d: alu=%h src=%b expected alu=%h src=%b", s, alu11, src11, e.alu, e.src);
      end
    end
    // Full-width immediate ignores SignExt.
    drive(16'd0, 16'h8001, 1'b1, 1'b1);
    sb.push_back(model(16'd0, 16'h8001, 1'b0, 1'b1, 16));
    settle();
    e = sb.pop_front();
    total++;
    if (alu !== e.alu) begin
      bad++;
      $display("FAIL full_width_ext: alu=%h expected %h", alu, e.alu);
    end
  endtask

  task automatic test_selb_x();
    drive(16'h1234, 16'hABCD, 1'b0, 1'bx);
    sb.push_back(model(16'h1234, 16'hABCD, 1'b0, 1'bx, 16));
    settle();
    e = sb.pop_front();
    total++;
    if ({alu, alu_src} !== {e.alu, e.src}) begin
      bad++;
      $display("FAIL selb_x: alu=%h src=%b expected alu=%h src=%b", alu, alu_src, e.alu, e.src);
    end
  endtask

  task automatic test_back_to_back();
    hold16 = '{alu: alu, src: alu_src, zero: alu_zero};
    hold11 = '{alu: alu11, src: src11, zero: zero11};
    for (int i = 0; i < 24; i++) begin
      operand_t    m;
      logic [15:0] im;
      logic        sx, sb_sel, en_r;
      m      = (i % 5 == 0) ? 16'd0 : 16'($urandom);
      im     = (i % 7 == 0) ? 16'd0 : 16'($urandom);
      sx     = 1'($urandom);
      sb_sel = 1'($urandom);
      en_r   = 1'($urandom);
      drive(m, im, sx, sb_sel);
      En = en_r;
`ifdef MUXB_REG_OUT_EN
      if (en_r) begin
        hold16 = model(m, im, sx, sb_sel, 16);
        hold11 = model(m, im, sx, sb_sel, 11);
      end
`else
      hold16 = model(m, im, sx, sb_sel, 16);
      hold11 = model(m, im, sx, sb_sel, 11);
`endif
      sb.push_back(hold16);
      sb.push_back(hold11);
      settle();
      e = sb.pop_front();
      total++;
      if ({alu, alu_zero, alu_src} !== {e.alu, e.zero, e.src}) begin
        bad++;
        $display("FAIL b2b16[%0d]: alu=%h zero=%b src=%b expected alu=%h zero=%b src=%b", i, alu, alu_zero, alu_src, e.alu, e.zero, e.src);
      end
      e = sb.pop_front();
      total++;
      if ({alu11, zero11, src11} !== {e.alu, e.zero, e.src}) begin
        bad++;
        $display("FAIL b2b11[%0d]: alu=%h zero=%b src=%b expected alu=%h zero=%b src=%b", i, alu11, zero11, src11, e.alu, e.zero, e.src);
      end
    end
    En = 1'b1;
  endtask

`ifdef MUXB_REG_OUT_EN
  task automatic test_reg_reset();
    drive(16'd247, 16'd2222, 1'b0, 1'b1);
    #3;
    total++;
    if ({alu, alu_zero, alu_src} !== {16'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reg_reset: alu=%h zero=%b src=%b expected alu=0000 zero=1 src=0", alu, alu_zero, alu_src);
    end
    @(posedge Clk);
    #1;
    total++;
    if (alu !== 16'd0) begin
      bad++;
      $display("FAIL reg_reset_edge: alu=%h expected 0000", alu);
    end
  endtask

  task automatic test_reg_capture_hold();
    @(negedge Clk);
    Rst_n = 1'b1;
    En    = 1'b1;
    drive(16'd247, 16'd2222, 1'b0, 1'b0);
    sb.push_back(model(16'd247, 16'd2222, 1'b0, 1'b0, 16));
    #1;
    total++;
    if (alu !== 16'd0) begin
      bad++;
      $display("FAIL reg_before_edge: alu=%h expected 0000", alu);
    end
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    total++;
    if ({alu, alu_src} !== {e.alu, e.src}) begin
      bad++;
      $display("FAIL reg_capture: alu=%h src=%b expected alu=%h src=%b", alu, alu_src, e.alu, e.src);
    end
    En = 1'b0;
    drive(16'd247, 16'd2222, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    total++;
    if ({alu, alu_src} !== {16'd247, 1'b0}) begin
      bad++;
      $display("FAIL reg_hold: alu=%h src=%b expected alu=00f7 src=0", alu, alu_src);
    end
  endtask

  task automatic test_reg_mid_reset();
    En = 1'b1;
    drive(16'd247, 16'd2222, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    total++;
    if (alu !== 16'd2222) begin
      bad++;
      $display("FAIL reg_pre_reset: alu=%h expected %h", alu, 16'd2222);
    end
    #1;
    Rst_n = 1'b0;
    #1;
    total++;
    if ({alu, alu_zero, alu_src} !== {16'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reg_mid_reset: alu=%h zero=%b src=%b expected alu=0000 zero=1 src=0", alu, alu_zero, alu_src);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask
`endif

  initial begin
    Rst_n = 1'b0;
    En    = 1'b1;
    drive(16'd0, 16'd0, 1'b0, 1'b0);
`ifdef MUXB_REG_OUT_EN
    test_reg_reset();
    test_reg_capture_hold();
    test_reg_mid_reset();
`endif
    Rst_n = 1'b1;
    En    = 1'b1;
    test_zero();
    test_memory();
    test_immediate();
    test_sign_ext();
    test_selb_x();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
